// File: rtl/data_proc_dl_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor and its counters.
package data_proc_dl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SUSPECT = 2'd1,
      BLOCKED = 2'd2
   } dl_state_e;

   localparam int DL_N_AXIS = 3;
   localparam int DL_N_INST = 2;
   localparam int DL_N_SUB  = 1;
   localparam int DL_THRESH = 16;
   localparam int DL_CNT_W  = 16;
   localparam int DL_STICKY = 1;

   // Counters of up to 32 bits share this helper; callers truncate the result back to their width.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v >= max) ? max : v + 32'd1;
   endfunction

endpackage

// File: rtl/data_proc_dl_sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear beats load, load beats increment.
module data_proc_dl_sat_counter
   import data_proc_dl_pkg::*;
#(
   parameter int             W   = 16,
   parameter logic [W-1:0]   MAX = '1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i) begin
         cnt_d = W'(sat_inc(32'(cnt_q), 32'(MAX)));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/data_proc_hls_deadlock_monitor_v2.sv
// Deadlock monitor for one HLS dataflow region: filters the raw stall condition over THRESH
// cycles, then flags the block, snapshots its source and measures its duration.
module data_proc_hls_deadlock_monitor_v2
   import data_proc_dl_pkg::*;
#(
   parameter int N_AXIS = DL_N_AXIS,
   parameter int N_INST = DL_N_INST,
   parameter int N_SUB  = DL_N_SUB,
   parameter int THRESH = DL_THRESH,
   parameter int CNT_W  = DL_CNT_W,
   parameter int STICKY = DL_STICKY
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [N_AXIS-1:0]       axis_block_sigs,
   input  logic [N_INST-1:0]       inst_idle_sigs,
   input  logic [N_INST-1:0]       inst_block_sigs,
   input  logic [N_SUB-1:0]        sub_block,
   input  logic                    clear,
   output logic                    block,
   output logic                    block_event,
   output logic [N_AXIS+N_SUB-1:0] block_src,
   output logic [CNT_W-1:0]        block_cycles
);

   localparam int             RW     = $clog2(THRESH + 1);
   localparam logic [RW-1:0]  THR_Q  = RW'(THRESH);
   localparam logic [RW-1:0]  THR_M1 = RW'(THRESH - 1);

   dl_state_e                 state_q, state_d;
   logic                      raw;
   logic                      entry;
   logic [RW-1:0]             run_cnt;
   logic                      block_q;
   logic                      event_q;
   logic [N_AXIS+N_SUB-1:0]   src_q;

   // An idle instance is never considered stuck, whatever its block flag says.
   assign raw = (|axis_block_sigs) | (|sub_block) | (|(inst_block_sigs & ~inst_idle_sigs));

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (raw) begin
                  state_d = (THRESH == 1) ? BLOCKED : SUSPECT;
               end
            end
            SUSPECT: begin
               if (!raw) begin
                  state_d = IDLE;
               end else if (run_cnt == THR_M1) begin
                  state_d = BLOCKED;
               end
            end
            BLOCKED: begin
               if ((STICKY == 0) && !raw) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      entry = !clear && (state_d == BLOCKED) && (state_q != BLOCKED);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         block_q <= 1'b0;
         event_q <= 1'b0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         block_q <= (state_d == BLOCKED);
         event_q <= entry;
         if (clear) begin
            src_q <= '0;
         end else if (entry) begin
            src_q <= {sub_block, axis_block_sigs};
         end
      end
   end

   // Consecutive raw cycles; any gap or a clear restarts detection from zero.
   data_proc_dl_sat_counter #(
      .W   (RW),
      .MAX (THR_Q)
   ) u_run_cnt (
      .clock      (clock),
      .reset      (reset),
      .clr_i      (clear | ~raw),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (1'b1),
      .cnt_o      (run_cnt)
   );

   // Duration counter holds its value after a non-sticky exit until the next entry or clear.
   data_proc_dl_sat_counter #(
      .W   (CNT_W),
      .MAX ('1)
   ) u_block_cycles (
      .clock      (clock),
      .reset      (reset),
      .clr_i      (clear),
      .load_i     (entry),
      .load_val_i (CNT_W'(1)),
      .inc_i      ((state_q == BLOCKED) && (state_d == BLOCKED)),
      .cnt_o      (block_cycles)
   );

   assign block       = block_q;
   assign block_event = event_q;
   assign block_src   = src_q;

endmodule

// File: tb/tb_data_proc_hls_deadlock_monitor_v2.sv
// Three monitor configurations share one randomized stimulus stream and are compared each cycle
// against a streak-based behavioural model.
module tb_data_proc_hls_deadlock_monitor_v2;

   logic       clock;
   logic       reset;
   logic [2:0] axis;
   logic [1:0] instIdle;
   logic [1:0] instBlock;
   logic [0:0] sub;
   logic       clear;

   logic       blkA, evtA, blkB, evtB, blkC, evtC;
   logic [3:0] srcA, srcB, srcC;
   logic [15:0] cycA, cycB;
   logic [3:0]  cycC;

   int vecCount  = 0;
   int missCount = 0;

   int         mThr[3]    = '{4, 1, 2};
   int         mSticky[3] = '{1, 0, 0};
   int         mMax[3]    = '{65535, 65535, 15};
   int         mStreak[3];
   logic       mBlk[3];
   logic       mEvt[3];
   logic [3:0] mSrc[3];
   int         mCyc[3];

   data_proc_hls_deadlock_monitor_v2 #(
      .N_AXIS(3), .N_INST(2), .N_SUB(1), .THRESH(4), .CNT_W(16), .STICKY(1)
   ) dutA (
      .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(instIdle),
      .inst_block_sigs(instBlock), .sub_block(sub), .clear(clear), .block(blkA),
      .block_event(evtA), .block_src(srcA), .block_cycles(cycA)
   );

   data_proc_hls_deadlock_monitor_v2 #(
      .N_AXIS(3), .N_INST(2), .N_SUB(1), .THRESH(1), .CNT_W(16), .STICKY(0)
   ) dutB (
      .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(instIdle),
      .inst_block_sigs(instBlock), .sub_block(sub), .clear(clear), .block(blkB),
      .block_event(evtB), .block_src(srcB), .block_cycles(cycB)
   );

   data_proc_hls_deadlock_monitor_v2 #(
      .N_AXIS(3), .N_INST(2), .N_SUB(1), .THRESH(2), .CNT_W(4), .STICKY(0)
   ) dutC (
      .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(instIdle),
      .inst_block_sigs(instBlock), .sub_block(sub), .clear(clear), .block(blkC),
      .block_event(evtC), .block_src(srcC), .block_cycles(cycC)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic calcRaw();
      return (|axis) || (|sub) || (|(instBlock & ~instIdle));
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         mStreak[k] = 0;
         mBlk[k]    = 1'b0;
         mEvt[k]    = 1'b0;
         mSrc[k]    = 4'd0;
         mCyc[k]    = 0;
      end
   endtask

   // A block is declared once the raw condition has held for thr full cycles in a row.
   task automatic modelStep();
      logic r;
      int   streak;
      r = calcRaw();
      for (int k = 0; k < 3; k++) begin
         mEvt[k] = 1'b0;
         if (clear) begin
            mStreak[k] = 0;
            mBlk[k]    = 1'b0;
            mSrc[k]    = 4'd0;
            mCyc[k]    = 0;
         end else begin
            streak = r ? mStreak[k] + 1 : 0;
            if (streak > 1000000) streak = 1000000;
            if (mBlk[k]) begin
               if (mSticky[k] != 0 || r) begin
                  mCyc[k] = (mCyc[k] >= mMax[k]) ? mMax[k] : mCyc[k] + 1;
               end else begin
                  mBlk[k] = 1'b0;
               end
            end else if (streak >= mThr[k]) begin
               mBlk[k] = 1'b1;
               mEvt[k] = 1'b1;
               mSrc[k] = {sub, axis};
               mCyc[k] = 1;
            end
            mStreak[k] = streak;
         end
      end
   endtask

   task automatic checkInst(input int k, input logic b, input logic e, input logic [3:0] s,
                            input logic [31:0] c);
      checkOutput($sformatf("i%0d.block", k), {31'b0, b}, {31'b0, mBlk[k]});
      checkOutput($sformatf("i%0d.block_event", k), {31'b0, e}, {31'b0, mEvt[k]});
      checkOutput($sformatf("i%0d.block_src", k), {28'b0, s}, {28'b0, mSrc[k]});
      checkOutput($sformatf("i%0d.block_cycles", k), c, 32'(mCyc[k]));
   endtask

   task automatic checkAll();
      checkInst(0, blkA, evtA, srcA, 32'(cycA));
      checkInst(1, blkB, evtB, srcB, 32'(cycB));
      checkInst(2, blkC, evtC, srcC, 32'(cycC));
   endtask

   task automatic tick();
      @(posedge clock);
      modelStep();
      #1;
      checkAll();
   endtask

   // Drives one input pattern for n cycles; clearAt selects a cycle that carries a clear pulse.
   task automatic applyStimulus(input logic [2:0] a, input logic s, input logic [1:0] ib,
                                input logic [1:0] ii, input int n, input int clearAt);
      axis      = a;
      sub       = s;
      instBlock = ib;
      instIdle  = ii;
      for (int j = 0; j < n; j++) begin
         clear = (j == clearAt);
         tick();
      end
      clear = 1'b0;
   endtask

   initial begin
      int len;
      int clrAt;
      reset     = 1'b0;
      axis      = '0;
      sub       = '0;
      instBlock = '0;
      instIdle  = '0;
      clear     = 1'b0;
      modelReset();
      repeat (2) @(posedge clock);
      #1;
      checkAll();
      reset = 1'b1;

      applyStimulus(3'b010, 1'b0, 2'b00, 2'b00, 3, -1);
      applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, 3, -1);
      applyStimulus(3'b010, 1'b0, 2'b00, 2'b00, 8, -1);
      applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, 2, -1);
      applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, 1, 0);

      applyStimulus(3'b000, 1'b0, 2'b01, 2'b01, 3, -1);
      applyStimulus(3'b000, 1'b0, 2'b01, 2'b00, 3, -1);
      applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, 2, 1);

      applyStimulus(3'b000, 1'b1, 2'b00, 2'b00, 20, -1);
      applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, 3, -1);
      applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, 2, 0);

      applyStimulus(3'b001, 1'b0, 2'b00, 2'b00, 40, -1);
      applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, 3, 2);

      // Reset pulse lands between clock edges while the sticky instance is blocked.
      applyStimulus(3'b100, 1'b0, 2'b00, 2'b00, 6, -1);
      #3;
      reset = 1'b0;
      modelReset();
      #1;
      checkAll();
      #2;
      reset = 1'b1;
      applyStimulus(3'b100, 1'b0, 2'b00, 2'b00, 6, -1);
      applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, 1, 0);

      for (int p = 0; p < 200; p++) begin
         len   = $urandom_range(1, 25);
         clrAt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
         if ($urandom_range(0, 3) == 0) begin
            applyStimulus(3'b000, 1'b0, 2'b00, 2'b00, len, clrAt);
         end else begin
            applyStimulus(($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000,
                          ($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom), len, clrAt);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/data_proc_hls_deadlock_monitor_v2.md
Name: data_proc_hls_deadlock_monitor_v2

Overview:
Parametrised deadlock monitor for an HLS dataflow region. It generalises the fixed single-instance monitor to any number of AXIS channels, process instances and child monitors. A raw block condition must persist for THRESH consecutive cycles before `block` is declared, which filters transient back-pressure. It optionally latches the condition (sticky), records which source caused it, and measures how long it lasted. One instance sits per dataflow region, and child outputs feed the parent's `sub_block` inputs.

Parameters:
- N_AXIS, 3, number of AXIS block inputs (>=1)
- N_INST, 2, number of process instances (>=1)
- N_SUB, 1, number of child-monitor block inputs (>=1; tie unused bits to 0)
- THRESH, 16, consecutive raw-block cycles required to declare a block (>=1)
- CNT_W, 16, width of the duration counter; must satisfy 2^CNT_W > THRESH
- STICKY, 1, 1 = block latched until `clear`; 0 = block drops when the raw condition drops

Ports:
- clock, in, 1, single clock, rising edge
- reset, in, 1, asynchronous, active-low
- axis_block_sigs, in, N_AXIS, per-channel AXIS stall (full/empty while blocked)
- inst_idle_sigs, in, N_INST, per-instance idle
- inst_block_sigs, in, N_INST, per-instance blocked
- sub_block, in, N_SUB, block outputs of child monitors
- clear, in, 1, synchronous clear of latched state and counters
- block, out, 1, deadlock declared
- block_event, out, 1, one-cycle pulse on entry to BLOCKED
- block_src, out, N_AXIS+N_SUB, snapshot of {sub_block, axis_block_sigs} at entry to BLOCKED
- block_cycles, out, CNT_W, cycles spent in BLOCKED, saturating

Behaviour:
- Raw condition (combinational): raw = |axis_block_sigs | |sub_block | |(inst_block_sigs & ~inst_idle_sigs). An instance that is idle never contributes.
- Reset (reset=0, asynchronous): state=IDLE, run_cnt=0, and all outputs 0 (block, block_event, block_src, block_cycles).
- run_cnt counts consecutive cycles with raw=1. It is cleared whenever raw=0 and saturates at THRESH.
- FSM state IDLE:
  - raw=1 and THRESH=1: go to BLOCKED.
  - raw=1 otherwise: go to SUSPECT with run_cnt=1.
- FSM state SUSPECT:
  - raw=0: go to IDLE and clear run_cnt.
  - raw=1 and run_cnt==THRESH-1: go to BLOCKED.
- FSM state BLOCKED:
  - block=1.
  - STICKY=0 and raw=0: go to IDLE; block falls on the next edge.
  - STICKY=1: stay in BLOCKED until clear.
- Latency: `block` rises on the clock edge after the THRESH-th consecutive raw cycle. With THRESH=1 this is one cycle, the same as the earlier monitor.
- On entry to BLOCKED:
  - block_event=1 for exactly one cycle.
  - block_src is registered from the current {sub_block, axis_block_sigs} and then held until the next entry or until clear.
  - block_cycles loads 1.
- While in BLOCKED, block_cycles increments each cycle and saturates at 2^CNT_W-1. It holds its value after leaving BLOCKED (non-sticky) until the next entry or clear.
- clear=1 has priority over all transitions:
  - next state=IDLE, run_cnt=0, block=0, block_src=0, block_cycles=0, no block_event.
  - If raw=1 during clear, detection restarts from run_cnt=0 on the following cycle.
- A raw drop exactly on the THRESH-th cycle means no entry: the condition must hold THRESH full cycles.
- Reset asserted mid-SUSPECT or mid-BLOCKED returns everything to reset values immediately. There is no effect until reset is released, and release is synchronised internally by the integrator's reset bridge.
- Width rules:
  - run_cnt width is $clog2(THRESH+1).
  - All reductions are over the full parameter widths.
  - No X-propagation is allowed from tied-off inputs.

Decomposition:
- Shared package data_proc_dl_pkg holds:
  - the FSM state enum (IDLE, SUSPECT, BLOCKED; 2 bits)
  - a saturating-increment function
  - default parameter constants
- One sub-module: data_proc_dl_sat_counter (parametrised width, load/inc/clear, saturates at max), instantiated for run_cnt and block_cycles.
- The raw reduction and FSM stay in the top module.

Test Plan:
- Pulse test (THRESH=4): axis_block_sigs[1]=1 for 3 cycles then 0 -> block never asserts and block_event stays 0.
- Entry and snapshot (THRESH=4): axis_block_sigs=3'b010 held -> block=1 on the edge after cycle 4; block_event is a single pulse; block_src=4'b0010.
- Idle masking (THRESH=1): inst_block_sigs=2'b01 with inst_idle_sigs=2'b01 -> no block; then drop idle[0] -> block asserts 1 cycle later.
- Sticky vs non-sticky (sub_block[0]=1 for 20 cycles, THRESH=2):
  - STICKY=1: block stays 1 after the input drops; clear -> block=0, block_cycles=0.
  - STICKY=0: block drops one cycle after the input drops; block_cycles=19.
- Saturation (CNT_W=4, THRESH=2): hold raw for 40 cycles -> block_cycles stops at 15.
- Async reset (STICKY=1): assert reset=0 mid-BLOCKED between clock edges -> all outputs 0 immediately; after release with raw=1, full THRESH cycles are needed again.
